// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic {BLANK, SHOW} scan_state_t;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  // One displayable frame: nibbles, decimal points and per-digit enables.
  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  digit_en;
  } disp_buf_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// User-logic side and board-pin side signals of the seven-segment scan controller.
interface seg7_scan_ctrl_if;

  logic        en;
  logic        load;
  logic [31:0] value;
  logic [7:0]  dp;
  logic [7:0]  digit_en;
  logic [2:0]  sel;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  modport master (
    output en, load, value, dp, digit_en,
    input  sel, an, seg, dp_n, frame_done
  );

  modport slave (
    input  en, load, value, dp, digit_en,
    output sel, an, seg, dp_n, frame_done
  );

endinterface

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 8-digit common-anode scan controller with per-slot blanking and a
// frame-synchronous double buffer for the displayed value.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic              clk,
  input logic              rst_n,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int                CNT_W      = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]        SEL_LAST   = 3'(NUM_DIGITS - 1);

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       sel_nxt;
  logic             boundary;

  disp_buf_t        act, act_nxt;
  disp_buf_t        pend, pend_nxt;
  logic             pend_vld, pend_vld_nxt;
  disp_buf_t        incoming;

  logic [3:0]       nib;
  logic [6:0]       seg_dec;
  logic [7:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_n_nxt;

  assign incoming = '{value: bus.value, dp: bus.dp, digit_en: bus.digit_en};

  // Scan sequencing: slot counter, digit index and blank/show phase.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = bus.sel;
    boundary  = 1'b0;
    if (!bus.en) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      sel_nxt   = '0;
    end else begin
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      case (state)
        BLANK: if (cnt == BLANK_LAST) state_nxt = SHOW;
        SHOW: begin
          if (cnt == CNT_LAST) begin
            state_nxt = BLANK;
            sel_nxt   = bus.sel + 1'b1;
            boundary  = (bus.sel == SEL_LAST);
          end
        end
        default: state_nxt = BLANK;
      endcase
    end
  end

  // A load landing exactly on the frame boundary bypasses the pending buffer.
  always_comb begin
    act_nxt      = act;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    if (boundary) begin
      if (bus.load)     act_nxt = incoming;
      else if (pend_vld) act_nxt = pend;
      pend_vld_nxt = 1'b0;
    end else if (bus.load) begin
      pend_nxt     = incoming;
      pend_vld_nxt = 1'b1;
    end
  end

  // Pin values for the upcoming state; act is stable whenever SHOW is next.
  assign nib = act.value[{sel_nxt, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nib),
    .seg    (seg_dec)
  );

  always_comb begin
    an_nxt   = AN_OFF;
    seg_nxt  = SEG_OFF;
    dp_n_nxt = 1'b1;
    if (state_nxt == SHOW) begin
      if (act.digit_en[sel_nxt]) an_nxt = ~(8'b1 << sel_nxt);
      seg_nxt  = seg_dec;
      dp_n_nxt = ~(act.dp[sel_nxt] & act.digit_en[sel_nxt]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BLANK;
      cnt            <= '0;
      act            <= '0;
      pend           <= '0;
      pend_vld       <= 1'b0;
      bus.sel        <= '0;
      bus.an         <= AN_OFF;
      bus.seg        <= SEG_OFF;
      bus.dp_n       <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      act            <= act_nxt;
      pend           <= pend_nxt;
      pend_vld       <= pend_vld_nxt;
      bus.sel        <= sel_nxt;
      bus.an         <= an_nxt;
      bus.seg        <= seg_nxt;
      bus.dp_n       <= dp_n_nxt;
      bus.frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized scoreboard bench for seg7_scan_ctrl against a cycle-count display model.
module tb_seg7_scan_ctrl;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FR = DC * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic [2:0] sel;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_on = 1'b0;
  bit   fd_armed = 1'b0;
  int   since = 0;
  exp_t mexp;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: enabled-cycle count since scan start, plus shown and queued frames.
  int          m_tick;
  logic [31:0] m_av, m_pval;
  logic [7:0]  m_adp, m_aden, m_pdp, m_pden;
  bit          m_pvld;

  function automatic exp_t dark();
    exp_t e;
    e.an = 8'hFF; e.seg = 7'h7F; e.dp_n = 1'b1; e.sel = 3'd0; e.fd = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_tick = 0; m_av = '0; m_adp = '0; m_aden = '0;
    m_pval = '0; m_pdp = '0; m_pden = '0; m_pvld = 1'b0;
  endtask

  // Apply inputs for this cycle and queue the pins expected after the next edge.
  task automatic drive(input bit e, input bit l, input logic [31:0] v,
                       input logic [7:0] d, input logic [7:0] de);
    exp_t x;
    bit   bdry;
    int   p, dg;
    bus.en = e; bus.load = l; bus.value = v; bus.dp = d; bus.digit_en = de;
    bdry = e && ((m_tick % FR) == FR - 1);
    if (bdry) begin
      if (l) begin
        m_av = v; m_adp = d; m_aden = de;
      end else if (m_pvld) begin
        m_av = m_pval; m_adp = m_pdp; m_aden = m_pden;
      end
      m_pvld = 1'b0;
    end else if (l) begin
      m_pval = v; m_pdp = d; m_pden = de; m_pvld = 1'b1;
    end
    m_tick = e ? m_tick + 1 : 0;
    x = dark();
    if (e) begin
      p  = m_tick % DC;
      dg = (m_tick / DC) % 8;
      x.sel = 3'(dg);
      x.fd  = bdry;
      if (p >= BC) begin
        if (m_aden[dg]) x.an = ~(8'h01 << dg);
        x.seg  = dec[m_av[dg*4 +: 4]];
        x.dp_n = ~(m_adp[dg] & m_aden[dg]);
      end
    end
    q.push_back(x);
  endtask

  task automatic step(input bit e, input bit l, input logic [31:0] v,
                      input logic [7:0] d, input logic [7:0] de);
    @(posedge clk);
    #1;
    drive(e, l, v, d, de);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  task automatic run_to(input int phase);
    int guard = 0;
    while ((m_tick % FR) != phase && guard < 4 * FR) begin
      step(1'b1, 1'b0, $urandom, 8'($urandom), 8'($urandom));
      guard++;
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_an"},   bus.an, 8'hFF);
    check({tag, "_seg"},  bus.seg, 7'h7F);
    check({tag, "_dp_n"}, bus.dp_n, 1'b1);
    check({tag, "_sel"},  bus.sel, 3'd0);
    check({tag, "_fd"},   bus.frame_done, 1'b0);
  endtask

  task automatic release_reset();
    model_reset();
    q.delete();
    q.push_back(dark());
    fd_armed = 1'b0;
    since = 0;
    rst_n = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    mon_on = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_pins("async_rst");
    @(posedge clk);
    #2 release_reset();
    drive(1'b1, 1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL queue_underflow actual=empty required=entry at %0t", $time);
      end else begin
        mexp = q.pop_front();
        check("an", bus.an, mexp.an);
        check("seg", bus.seg, mexp.seg);
        check("dp_n", bus.dp_n, mexp.dp_n);
        check("sel", bus.sel, mexp.sel);
        check("frame_done", bus.frame_done, mexp.fd);
      end
      check("an_onehot", 32'($countones(~bus.an) <= 1), 1);
      since++;
      if (bus.frame_done) begin
        if (fd_armed) check("fd_period", since, FR);
        fd_armed = 1'b1;
        since = 0;
      end
      if (!bus.en) fd_armed = 1'b0;
    end
  end

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.digit_en = '0;
    #12 check_reset_pins("reset");
    @(posedge clk);
    #2 release_reset();

    // Count-up digits, visible from the second frame on.
    drive(1'b1, 1'b1, 32'h76543210, 8'h00, 8'hFF);
    idle(2 * FR);

    // Mid-frame load at digit 3 SHOW waits for the boundary.
    run_to(3 * DC + 4);
    step(1'b1, 1'b1, 32'hFFFFFFFF, 8'h00, 8'hFF);
    run_to(0);
    idle(FR + DC);

    // Odd digits only; dp on a dark digit, then on a lit one.
    step(1'b1, 1'b1, $urandom, 8'h01, 8'b1010_1010);
    idle(2 * FR);
    step(1'b1, 1'b1, 32'h89ABCDEF, 8'h02, 8'b1010_1010);
    idle(2 * FR);

    // Stale pending replaced by a load on the boundary cycle itself.
    run_to(10);
    step(1'b1, 1'b1, $urandom, 8'($urandom), 8'hFF);
    run_to(FR - 1);
    step(1'b1, 1'b1, 32'h0, 8'h00, 8'hFF);
    idle(2 * FR + 4);

    // Disable during digit 5 SHOW, load while dark, re-enable.
    run_to(5 * DC + 4);
    step(1'b0, 1'b0, $urandom, 8'($urandom), 8'($urandom));
    step(1'b0, 1'b1, 32'hFEDCBA98, 8'h5A, 8'hFF);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $urandom, 8'($urandom), 8'($urandom));
    idle(FR + 16);

    // Asynchronous reset during SHOW.
    run_to(2 * DC + 5);
    do_reset();
    step(1'b1, 1'b1, $urandom, 8'($urandom), 8'hFF);
    idle(2 * FR + 2);

    // Random enables and loads.
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 60) != 0, ($urandom % 16) == 0, $urandom, 8'($urandom), 8'($urandom));
    end
    idle(4);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
